// File: rtl/phase_cmd_parser.sv
// phase_cmd_parser
//   Decodes command frames arriving as a byte stream (already in the sys_clk
//   domain) into per-channel phase values. Writes go to a shadow bank; a
//   COMMIT copies the whole shadow bank to the active outputs in one cycle,
//   so every channel switches phase on the same clock.
//
//   Frames (first byte is the opcode):
//     0x01 addr phase : shadow[addr] <= phase
//     0x02            : phases <= shadow, commit_pulse for one cycle
//     0x03 phase      : shadow[all] <= phase
//
// Ports
//   sys_clk       in   system clock, single clock domain
//   rst           in   synchronous active-high reset
//   rx_data       in   received byte
//   rx_valid      in   rx_data valid
//   rx_ready      out  byte can be accepted (always 1 outside reset)
//   err_clear     in   clears the sticky read_error flag
//   phases        out  active phase per channel, unpacked [0:NUM_CHANNELS-1]
//   commit_pulse  out  one-cycle strobe when the active bank is updated
//   read_error    out  sticky frame/protocol error flag
module phase_cmd_parser #(
    parameter int NUM_CHANNELS   = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    input  logic       err_clear,
    output logic [7:0] phases [NUM_CHANNELS],
    output logic       commit_pulse,
    output logic       read_error
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] OP_SET    = 8'h01;
    localparam logic [7:0] OP_COMMIT = 8'h02;
    localparam logic [7:0] OP_SETALL = 8'h03;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GET_ADDR  = 2'd1,
        GET_PHASE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          all_q, all_d;        // current frame is SET_ALL
    logic [7:0]    addr_q, addr_d;
    logic [CW-1:0] cnt_q, cnt_d;        // idle cycles since last byte of a frame
    logic [7:0]    shadow_q [NUM_CHANNELS];
    logic [7:0]    shadow_d [NUM_CHANNELS];
    logic [7:0]    phases_q [NUM_CHANNELS];
    logic [7:0]    phases_d [NUM_CHANNELS];
    logic          commit_q, commit_d;
    logic          err_q, err_d;
    logic          err_set;
    logic          rdy_q;
    logic          accept;
    logic          timeout;
    logic          addr_ok;

    // Gated with rst so the parser reports not-ready in the very cycle reset
    // is raised, not one cycle later.
    assign rx_ready     = rdy_q & ~rst;
    assign accept       = rx_valid & rx_ready;
    assign timeout      = (cnt_q == CW'(TIMEOUT_CYCLES));
    assign addr_ok      = ({1'b0, addr_q} < 9'(NUM_CHANNELS));
    assign phases       = phases_q;
    assign commit_pulse = commit_q;
    assign read_error   = err_q;

    always_comb begin
        state_d  = state_q;
        all_d    = all_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        phases_d = phases_q;
        commit_d = 1'b0;
        err_set  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    case (rx_data)
                        OP_SET: begin
                            all_d   = 1'b0;
                            state_d = GET_ADDR;
                        end
                        OP_SETALL: begin
                            all_d   = 1'b1;
                            state_d = GET_PHASE;
                        end
                        OP_COMMIT: begin
                            phases_d = shadow_q;
                            commit_d = 1'b1;
                        end
                        default: err_set = 1'b1;   // unknown opcode dropped
                    endcase
                end
            end

            GET_ADDR: begin
                if (accept) begin
                    addr_d  = rx_data;
                    cnt_d   = '0;
                    state_d = GET_PHASE;
                end else if (timeout) begin
                    cnt_d   = '0;
                    err_set = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            GET_PHASE: begin
                if (accept) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (all_q) begin
                        for (int i = 0; i < NUM_CHANNELS; i++)
                            shadow_d[i] = rx_data;
                    end else if (addr_ok) begin
                        for (int i = 0; i < NUM_CHANNELS; i++)
                            if (addr_q == 8'(i))
                                shadow_d[i] = rx_data;
                    end else begin
                        // Out-of-range address: phase byte consumed, no write.
                        err_set = 1'b1;
                    end
                end else if (timeout) begin
                    cnt_d   = '0;
                    err_set = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // A new error in the same cycle as err_clear wins.
        if (err_set)
            err_d = 1'b1;
        else if (err_clear)
            err_d = 1'b0;
        else
            err_d = err_q;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q  <= IDLE;
            all_q    <= 1'b0;
            addr_q   <= '0;
            cnt_q    <= '0;
            commit_q <= 1'b0;
            err_q    <= 1'b0;
            rdy_q    <= 1'b0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                shadow_q[i] <= '0;
                phases_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            all_q    <= all_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            commit_q <= commit_d;
            err_q    <= err_d;
            rdy_q    <= 1'b1;
            shadow_q <= shadow_d;
            phases_q <= phases_d;
        end
    end

endmodule

// File: tb/tb_phase_cmd_parser.sv
// tb_phase_cmd_parser
//   Self-checking bench for phase_cmd_parser: directed vector table, a few
//   hand-written multi-cycle sequences (timeout boundary, reset mid-frame)
//   and randomized byte streams compared against a frame-level model.
module tb_phase_cmd_parser;

    localparam int N  = 2;
    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic       err_clear = 1'b0;
    logic [7:0] phases [N];
    logic       commit_pulse;
    logic       read_error;

    int nchk  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    phase_cmd_parser #(.NUM_CHANNELS(N), .TIMEOUT_CYCLES(TO)) dut (
        .sys_clk     (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .err_clear   (err_clear),
        .phases      (phases),
        .commit_pulse(commit_pulse),
        .read_error  (read_error)
    );

    // ---------------- frame-level reference model ----------------
    logic [7:0] m_shadow [N];
    logic [7:0] m_active [N];
    logic       m_err;
    logic       m_pulse;
    logic [7:0] m_frame [$];
    int         m_gap;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_shadow[i] = 8'h00;
                m_active[i] = 8'h00;
            end
            m_err   = 1'b0;
            m_pulse = 1'b0;
            m_frame.delete();
            m_gap   = 0;
        end else begin
            logic ev;
            ev      = 1'b0;
            m_pulse = 1'b0;
            if (rx_valid && rx_ready) begin
                m_gap = 0;
                if (m_frame.size() == 0) begin
                    if (rx_data == 8'h01 || rx_data == 8'h03)
                        m_frame.push_back(rx_data);
                    else if (rx_data == 8'h02) begin
                        m_active = m_shadow;
                        m_pulse  = 1'b1;
                    end else
                        ev = 1'b1;
                end else begin
                    m_frame.push_back(rx_data);
                    if (m_frame[0] == 8'h03 && m_frame.size() == 2) begin
                        for (int i = 0; i < N; i++) m_shadow[i] = m_frame[1];
                        m_frame.delete();
                    end else if (m_frame[0] == 8'h01 && m_frame.size() == 3) begin
                        if (int'(m_frame[1]) < N) m_shadow[m_frame[1]] = m_frame[2];
                        else ev = 1'b1;
                        m_frame.delete();
                    end
                end
            end else if (m_frame.size() != 0) begin
                // A frame may sit idle for up to TO cycles; the next idle
                // cycle aborts it.
                if (m_gap == TO) begin
                    m_frame.delete();
                    m_gap = 0;
                    ev    = 1'b1;
                end else
                    m_gap++;
            end
            m_err = ev ? 1'b1 : (err_clear ? 1'b0 : m_err);
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; drives one cycle and returns at the next negedge.
    task automatic tick(input logic v, input logic [7:0] d, input logic c);
        rx_valid  = v;
        rx_data   = d;
        err_clear = c;
        @(posedge clk);
        @(negedge clk);
        rx_valid  = 1'b0;
        err_clear = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        tick(1'b1, d, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " phase0"}, {24'h0, phases[0]}, {24'h0, m_active[0]});
        chk({tag, " phase1"}, {24'h0, phases[1]}, {24'h0, m_active[1]});
        chk({tag, " pulse"}, {31'h0, commit_pulse}, {31'h0, m_pulse});
        chk({tag, " err"}, {31'h0, read_error}, {31'h0, m_err});
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       c;
        logic [7:0] p0;
        logic [7:0] p1;
        logic       pulse;
        logic       err;
    } vec_t;

    vec_t vecs [$];

    task automatic add(input logic v, input logic [7:0] d, input logic c,
                       input logic [7:0] p0, input logic [7:0] p1,
                       input logic pulse, input logic err);
        vec_t t;
        t.v = v; t.d = d; t.c = c; t.p0 = p0; t.p1 = p1; t.pulse = pulse; t.err = err;
        vecs.push_back(t);
    endtask

    initial begin
        // SET 0=5A, SET 1=A5, COMMIT
        add(1, 8'h01, 0, 8'h00, 8'h00, 0, 0);
        add(1, 8'h00, 0, 8'h00, 8'h00, 0, 0);
        add(1, 8'h5A, 0, 8'h00, 8'h00, 0, 0);
        add(1, 8'h01, 0, 8'h00, 8'h00, 0, 0);
        add(1, 8'h01, 0, 8'h00, 8'h00, 0, 0);
        add(1, 8'hA5, 0, 8'h00, 8'h00, 0, 0);
        add(1, 8'h02, 0, 8'h5A, 8'hA5, 1, 0);
        add(0, 8'h00, 0, 8'h5A, 8'hA5, 0, 0);
        // SET_ALL 33, COMMIT, back-to-back COMMIT
        add(1, 8'h03, 0, 8'h5A, 8'hA5, 0, 0);
        add(1, 8'h33, 0, 8'h5A, 8'hA5, 0, 0);
        add(1, 8'h02, 0, 8'h33, 8'h33, 1, 0);
        add(1, 8'h02, 0, 8'h33, 8'h33, 1, 0);
        add(0, 8'h00, 0, 8'h33, 8'h33, 0, 0);
        // SET 0=10 without commit
        add(1, 8'h01, 0, 8'h33, 8'h33, 0, 0);
        add(1, 8'h00, 0, 8'h33, 8'h33, 0, 0);
        add(1, 8'h10, 0, 8'h33, 8'h33, 0, 0);
        add(0, 8'h00, 0, 8'h33, 8'h33, 0, 0);
        // bad opcode, then a valid frame still decodes
        add(1, 8'h7E, 0, 8'h33, 8'h33, 0, 1);
        add(1, 8'h01, 0, 8'h33, 8'h33, 0, 1);
        add(1, 8'h01, 0, 8'h33, 8'h33, 0, 1);
        add(1, 8'h44, 0, 8'h33, 8'h33, 0, 1);
        add(1, 8'h02, 0, 8'h10, 8'h44, 1, 1);
        // err_clear, then clear colliding with a new error
        add(0, 8'h00, 1, 8'h10, 8'h44, 0, 0);
        add(1, 8'h7E, 1, 8'h10, 8'h44, 0, 1);
        add(0, 8'h00, 1, 8'h10, 8'h44, 0, 0);
        // out-of-range address
        add(1, 8'h01, 0, 8'h10, 8'h44, 0, 0);
        add(1, 8'h05, 0, 8'h10, 8'h44, 0, 0);
        add(1, 8'hFF, 0, 8'h10, 8'h44, 0, 1);
        add(1, 8'h02, 0, 8'h10, 8'h44, 1, 1);
        add(0, 8'h00, 1, 8'h10, 8'h44, 0, 0);
    end

    // ---------------- main sequence ----------------
    initial begin
        @(negedge clk);
        idle(2);
        chk("reset rx_ready", {31'h0, rx_ready}, 32'h0);
        chk("reset phase0", {24'h0, phases[0]}, 32'h0);
        chk("reset phase1", {24'h0, phases[1]}, 32'h0);
        chk("reset err", {31'h0, read_error}, 32'h0);
        chk("reset pulse", {31'h0, commit_pulse}, 32'h0);
        rst = 1'b0;
        idle(1);
        chk("post-reset rx_ready", {31'h0, rx_ready}, 32'h1);
        chk("post-reset err", {31'h0, read_error}, 32'h0);

        // Table
        for (int i = 0; i < vecs.size(); i++) begin
            string n;
            n = $sformatf("vec%0d", i);
            tick(vecs[i].v, vecs[i].d, vecs[i].c);
            chk({n, " phase0"}, {24'h0, phases[0]}, {24'h0, vecs[i].p0});
            chk({n, " phase1"}, {24'h0, phases[1]}, {24'h0, vecs[i].p1});
            chk({n, " pulse"}, {31'h0, commit_pulse}, {31'h0, vecs[i].pulse});
            chk({n, " err"}, {31'h0, read_error}, {31'h0, vecs[i].err});
            chk({n, " rx_ready"}, {31'h0, rx_ready}, 32'h1);
        end

        // Timeout: 01 00, gap past the limit, then 5A is decoded as an opcode.
        send(8'h01);
        send(8'h00);
        idle(TO + 3);
        chk("timeout err", {31'h0, read_error}, 32'h1);
        tick(1'b0, 8'h00, 1'b1);
        chk("timeout cleared", {31'h0, read_error}, 32'h0);
        send(8'h5A);
        chk("5A as opcode err", {31'h0, read_error}, 32'h1);
        send(8'h02);
        chk("timeout no write p0", {24'h0, phases[0]}, 32'h10);
        chk("timeout no write p1", {24'h0, phases[1]}, 32'h44);
        tick(1'b0, 8'h00, 1'b1);

        // Boundary: exactly TO idle cycles inside a frame is still allowed.
        send(8'h03);
        idle(TO);
        send(8'h77);
        send(8'h02);
        chk("gap=TO p0", {24'h0, phases[0]}, 32'h77);
        chk("gap=TO p1", {24'h0, phases[1]}, 32'h77);
        chk("gap=TO err", {31'h0, read_error}, 32'h0);

        // Reset while waiting for the phase byte.
        send(8'h01);
        send(8'h01);
        rst = 1'b1;
        #1;
        chk("rst rx_ready low", {31'h0, rx_ready}, 32'h0);
        idle(2);
        chk("rst mid p0", {24'h0, phases[0]}, 32'h0);
        chk("rst mid p1", {24'h0, phases[1]}, 32'h0);
        rst = 1'b0;
        idle(1);
        chk("rst mid rx_ready", {31'h0, rx_ready}, 32'h1);
        send(8'h5A);   // partial frame lost: 5A is an opcode
        chk("rst mid 5A err", {31'h0, read_error}, 32'h1);
        send(8'h02);
        chk("rst mid commit p0", {24'h0, phases[0]}, 32'h0);
        chk("rst mid commit p1", {24'h0, phases[1]}, 32'h0);

        // Randomized stream against the model.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] d;
            int r;
            if ($urandom_range(0, 99) < 3) begin
                int g;
                g = $urandom_range(TO - 2, TO + 2);
                for (int k = 0; k < g; k++) begin
                    tick(1'b0, 8'h00, 1'b0);
                    chk_model("rnd gap");
                end
            end
            r = $urandom_range(0, 9);
            if (r <= 2)      d = 8'h01;
            else if (r == 3) d = 8'h02;
            else if (r == 4) d = 8'h03;
            else if (r <= 7) d = 8'($urandom_range(0, 3));
            else             d = 8'($urandom_range(0, 255));
            tick(($urandom_range(0, 9) < 7), d, ($urandom_range(0, 19) == 0));
            chk_model("rnd");
        end

        $display("%0d/%0d checks passed", nchk - nfail, nchk);
        $finish;
    end

endmodule
